fft4_2d_sched: RTL and testbench

- Sequences one shared 4-point FFT core (complex_t vector in/out, next/next_out strobes) to compute a 4x4 2D FFT tile, using a row pass followed by a column pass.
- Accepts one tile over a valid/ready handshake and holds it in a single 16-entry complex_t buffer. Issues row and column vectors to the core, collects the results in place, and presents the finished tile over a valid/ready handshake.
- Sits between the conv-layer tile feeder and the fft4 core.

---
 rtl/fft4_2d_sched_pkg.sv | 23 ++
 rtl/fft4_2d_tile_buf.sv | 52 +++++
 rtl/fft4_2d_sched.sv | 144 ++++++++++++++
 tb/tb_fft4_2d_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft4_2d_sched_pkg.sv
// Shared types for the 4x4 2D FFT tile scheduler: complex sample, vector/tile
// containers and the scheduler state encoding.
package fft4_2d_sched_pkg;

    localparam int unsigned FFT_N  = 4;
    localparam int unsigned CPLX_W = 32;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } complex_t;

    typedef complex_t [0:FFT_N-1] vec_t;
    typedef vec_t     [0:FFT_N-1] tile_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_OUT
    } state_e;

endpackage

// File: rtl/fft4_2d_tile_buf.sv
// 4x4 complex tile store: full-tile load, row or column write of one vector,
// and a row/column read mux feeding the FFT core.
module fft4_2d_tile_buf
    import fft4_2d_sched_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  tile_t       load_tile_i,
    input  logic        row_we_i,
    input  logic        col_we_i,
    input  logic [1:0]  wr_idx_i,
    input  vec_t        wr_vec_i,
    input  logic        rd_col_i,
    input  logic [1:0]  rd_idx_i,
    output vec_t        rd_vec_o,
    output tile_t       tile_o
);

    tile_t buf_q, buf_d;

    always_comb begin
        buf_d = buf_q;
        if (load_i) begin
            buf_d = load_tile_i;
        end else if (row_we_i) begin
            buf_d[wr_idx_i] = wr_vec_i;
        end else if (col_we_i) begin
            for (int unsigned k = 0; k < FFT_N; k++) begin
                buf_d[2'(k)][wr_idx_i] = wr_vec_i[2'(k)];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    always_comb begin
        rd_vec_o = '0;
        for (int unsigned k = 0; k < FFT_N; k++) begin
            rd_vec_o[2'(k)] = rd_col_i ? buf_q[2'(k)][rd_idx_i] : buf_q[rd_idx_i][2'(k)];
        end
    end

    assign tile_o = buf_q;

endmodule

// File: rtl/fft4_2d_sched.sv
// Drives one shared 4-point FFT core through a row pass then a column pass to
// produce a 4x4 2D FFT tile, with a watchdog against lost core results.
module fft4_2d_sched
    import fft4_2d_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  tile_t            in_tile_i,
    output logic             fft_next_o,
    output vec_t             fft_in_o,
    input  logic             fft_next_out_i,
    input  vec_t             fft_out_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output tile_t            out_tile_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] tile_cnt_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [1:0]       iss_idx_q, iss_idx_d;
    logic             iss_done_q, iss_done_d;
    logic [2:0]       cap_cnt_q, cap_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;

    logic  active, issue, capture, load;
    vec_t  rd_vec;
    tile_t buf_tile;

    assign active  = (state_q == S_ROW) || (state_q == S_COL);
    assign issue   = active && !iss_done_q;
    assign capture = active && fft_next_out_i;

    always_comb begin
        state_d    = state_q;
        iss_idx_d  = iss_idx_q;
        iss_done_d = iss_done_q;
        cap_cnt_d  = cap_cnt_q;
        wd_d       = wd_q;
        err_d      = err_q;
        tile_cnt_d = tile_cnt_q;
        load       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    load    = 1'b1;
                    state_d = S_ROW;
                end
            end
            S_ROW, S_COL: begin
                // A result in the same cycle as the timeout keeps the tile alive.
                if (capture && cap_cnt_q == 3'd3) begin
                    state_d = (state_q == S_ROW) ? S_COL : S_OUT;
                end else if (!fft_next_out_i && wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    tile_cnt_d = tile_cnt_q + 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fft_next_out_i && !active) begin
            err_d = 1'b1;
        end

        if (state_d != state_q) begin
            iss_idx_d  = '0;
            iss_done_d = 1'b0;
            cap_cnt_d  = '0;
            wd_d       = '0;
        end else begin
            if (issue) begin
                iss_idx_d  = iss_idx_q + 1'b1;
                iss_done_d = (iss_idx_q == 2'd3);
            end
            if (capture) begin
                cap_cnt_d = cap_cnt_q + 1'b1;
            end
            wd_d = (active && !fft_next_out_i) ? wd_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            iss_idx_q  <= '0;
            iss_done_q <= 1'b0;
            cap_cnt_q  <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            tile_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            iss_idx_q  <= iss_idx_d;
            iss_done_q <= iss_done_d;
            cap_cnt_q  <= cap_cnt_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    fft4_2d_tile_buf u_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load),
        .load_tile_i (in_tile_i),
        .row_we_i    (capture && state_q == S_ROW),
        .col_we_i    (capture && state_q == S_COL),
        .wr_idx_i    (cap_cnt_q[1:0]),
        .wr_vec_i    (fft_out_i),
        .rd_col_i    (state_q == S_COL),
        .rd_idx_i    (iss_idx_q),
        .rd_vec_o    (rd_vec),
        .tile_o      (buf_tile)
    );

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign fft_next_o  = issue;
    assign fft_in_o    = issue ? rd_vec : '0;
    assign out_valid_o = (state_q == S_OUT);
    assign out_tile_o  = buf_tile;
    assign err_o       = err_q;
    assign tile_cnt_o  = tile_cnt_q;

endmodule

// File: tb/tb_fft4_2d_sched.sv
// Randomized bench for fft4_2d_sched: an ideal fft4 core model with selectable
// latency, a direct 2D DFT reference and a per-cycle schedule model.
module tb_fft4_2d_sched;
    import fft4_2d_sched_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    tile_t       in_tile = '0;
    logic        fft_next;
    vec_t        fft_in;
    logic        fft_next_out = 1'b0;
    vec_t        fft_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    tile_t       out_tile;
    logic        busy;
    logic        err;
    logic [15:0] tile_cnt;

    fft4_2d_sched #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_tile_i      (in_tile),
        .fft_next_o     (fft_next),
        .fft_in_o       (fft_in),
        .fft_next_out_i (fft_next_out),
        .fft_out_i      (fft_out),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_tile_o     (out_tile),
        .busy_o         (busy),
        .err_o          (err),
        .tile_cnt_o     (tile_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- arithmetic reference ----------------
    function automatic complex_t rot(complex_t x, int p);
        complex_t y;
        case (p % 4)
            0:       y = x;
            1:       begin y.re = x.im;  y.im = -x.re; end
            2:       begin y.re = -x.re; y.im = -x.im; end
            default: begin y.re = -x.im; y.im = x.re;  end
        endcase
        return y;
    endfunction

    function automatic complex_t cadd(complex_t a, complex_t b);
        complex_t y;
        y.re = a.re + b.re;
        y.im = a.im + b.im;
        return y;
    endfunction

    function automatic vec_t dft4(vec_t x);
        vec_t y = '0;
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 4; n++)
                y[k] = cadd(y[k], rot(x[n], n * k));
        return y;
    endfunction

    function automatic tile_t ref2d(tile_t x);
        tile_t y = '0;
        for (int k1 = 0; k1 < 4; k1++)
            for (int k2 = 0; k2 < 4; k2++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        y[k1][k2] = cadd(y[k1][k2], rot(x[r][c], r * k1 + c * k2));
        return y;
    endfunction

    function automatic tile_t rowpass(tile_t x);
        tile_t y;
        for (int r = 0; r < 4; r++) y[r] = dft4(x[r]);
        return y;
    endfunction

    // ---------------- core model ----------------
    typedef struct { int due; vec_t v; } pend_t;
    pend_t pq[$];
    pend_t pitem;
    int    core_lat = 1;
    int    drop_cd = 0;
    logic  stray_req = 1'b0;
    logic  drop_now;

    always begin
        @(posedge clk); #2;
        fft_next_out = 1'b0;
        fft_out = '0;
        if (reset) begin
            pq.delete();
        end else begin
            if (stray_req) begin
                fft_next_out = 1'b1;
                fft_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                stray_req = 1'b0;
            end else if (pq.size() > 0 && pq[0].due == cyc) begin
                pitem = pq.pop_front();
                drop_now = 1'b0;
                if (drop_cd > 0) begin
                    drop_cd--;
                    drop_now = (drop_cd == 0);
                end
                if (!drop_now) begin
                    fft_next_out = 1'b1;
                    fft_out = pitem.v;
                end
            end
            if (fft_next) pq.push_back('{cyc + core_lat, dft4(fft_in)});
        end
    end

    // ---------------- schedule model + compare ----------------
    logic  chk_en = 1'b0;
    logic  mdl_busy = 1'b0;
    int    acc_cyc, nxt_cnt, rel;
    int    exp_cnt = 0;
    tile_t exp_in_tile, exp_out, exp_rows;
    vec_t  ev;
    logic  row_slot, col_slot, ov;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            if (!mdl_busy) begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_fft_next", fft_next, 0);
                chk("idle_fft_in", fft_in, 0);
                chk("idle_out_valid", out_valid, 0);
                chk("idle_err", err, 0);
                chk("idle_tile_cnt", tile_cnt, 16'(exp_cnt));
                if (in_valid) begin
                    mdl_busy    = 1'b1;
                    acc_cyc     = cyc;
                    nxt_cnt     = 0;
                    exp_in_tile = in_tile;
                    exp_out     = ref2d(in_tile);
                    exp_rows    = rowpass(in_tile);
                end
            end else begin
                rel      = cyc - acc_cyc;
                row_slot = (rel >= 1) && (rel <= 4);
                col_slot = (rel >= 5 + core_lat) && (rel <= 8 + core_lat);
                ov       = (rel >= 9 + 2 * core_lat);
                ev       = '0;
                if (row_slot) ev = exp_in_tile[rel - 1];
                if (col_slot)
                    for (int k = 0; k < 4; k++) ev[k] = exp_rows[k][rel - 5 - core_lat];
                chk("busy_in_ready", in_ready, 0);
                chk("busy_busy", busy, 1);
                chk("busy_err", err, 0);
                chk("fft_next", fft_next, row_slot || col_slot);
                chk("fft_in", fft_in, ev);
                chk("out_valid", out_valid, ov);
                chk("busy_tile_cnt", tile_cnt, 16'(exp_cnt));
                if (fft_next) nxt_cnt++;
                if (ov) chk("out_tile", out_tile, exp_out);
                if (ov && out_ready) begin
                    chk("next_pulse_count", nxt_cnt, 8);
                    exp_cnt++;
                    mdl_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_tile(output tile_t t);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                t[r][c].re = int'($urandom_range(4000)) - 2000;
                t[r][c].im = int'($urandom_range(4000)) - 2000;
            end
    endtask

    task automatic run_tile(input tile_t t, input int lat, input int bp,
                            output tile_t res, output int ov_lat);
        int a;
        int n;
        core_lat  = lat;
        out_ready = (bp == 0);
        in_tile   = t;
        in_valid  = 1'b1;
        a         = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_wait", out_valid, 1);
        ov_lat = cyc - a;
        res = out_tile;
        repeat (bp) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    tile_t    t, res, lit, ot;
    complex_t ce;
    int       ovl, a, t_last;
    logic [15:0] cnt_before;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_tile", out_tile, 0);
        chk("rst_tile_cnt", tile_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (20) @(posedge clk);
        #1;

        // impulse, L = 3
        t = '0;
        t[0][0].re = 1;
        run_tile(t, 3, 0, res, ovl);
        chk("impulse_ov_latency", ovl, 15);
        lit = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) lit[r][c].re = 1;
        chk("impulse_tile", res, lit);
        chk("impulse_tile_cnt", tile_cnt, 1);

        // ramp, L = 1 and L = 5
        t = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c].re = 4 * r + c;
        run_tile(t, 1, 0, res, ovl);
        chk("ramp_l1_ov_latency", ovl, 11);
        ce.re = 120; ce.im = 0;
        chk("ramp_x00", res[0][0], ce);
        ce.re = -8;  ce.im = 8;
        chk("ramp_x01", res[0][1], ce);
        run_tile(t, 5, 0, res, ovl);
        chk("ramp_l5_ov_latency", ovl, 19);

        // backpressure
        run_tile(t, 2, 10, res, ovl);

        // random tiles
        for (int i = 0; i < 6; i++) begin
            rand_tile(t);
            run_tile(t, int'($urandom_range(6, 1)), int'($urandom_range(3, 0)), res, ovl);
        end

        // watchdog: third row result lost
        chk_en = 1'b0;
        cnt_before = tile_cnt;
        rand_tile(t);
        core_lat = 3;
        drop_cd  = 3;
        in_tile  = t;
        in_valid = 1'b1;
        a = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_last = a + 4 + 3;
        while (cyc != t_last + TO) @(negedge clk);
        chk("wd_err_before", err, 0);
        chk("wd_busy_before", busy, 1);
        @(negedge clk);
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        chk("wd_in_ready", in_ready, 1);
        chk("wd_tile_cnt", tile_cnt, cnt_before);
        ot = out_tile;
        @(posedge clk); #1;
        stray_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("stray_err", err, 1);
        chk("stray_out_tile", out_tile, ot);
        chk("stray_busy", busy, 0);

        // reset while in the column pass
        @(posedge clk); #1;
        rand_tile(t);
        core_lat = 3;
        in_tile  = t;
        in_valid = 1'b1;
        a = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("col_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(negedge clk);
        chk("rr_err", err, 0);
        chk("rr_out_tile", out_tile, 0);
        chk("rr_tile_cnt", tile_cnt, 0);
        chk("rr_in_ready", in_ready, 1);
        chk("rr_out_valid", out_valid, 0);
        repeat (10) @(negedge clk);
        chk("rr_err_later", err, 0);
        @(posedge clk); #1;
        exp_cnt = 0;
        chk_en  = 1'b1;
        t = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c].re = 2;
        run_tile(t, 2, 0, res, ovl);
        lit = '0;
        lit[0][0].re = 32;
        chk("const2_tile", res, lit);
        chk("const2_tile_cnt", tile_cnt, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule
